c3lib_sync_filt_multi: RTL and testbench

- Multi-channel, parametrised-depth synchroniser with per-bit reset value, glitch-rejecting stability filter and registered edge pulses.
- Successor to the fixed 2-stage, 1-bit preset synchroniser.
- Sits at asynchronous control and status inputs of AIB adapter/PHY blocks, e.g. sideband, ready/valid strobes, config straps.
- Replaces per-bit sync instances plus ad-hoc debounce and edge-detect logic.

---
 rtl/c3lib_sync_pkg.sv | 14 +
 rtl/c3lib_sync_filt_chan.sv | 61 ++++++
 rtl/c3lib_sync_filt_multi.sv | 78 +++++++
 tb/tb_c3lib_sync_filt_multi.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/c3lib_sync_pkg.sv
// Shared limits, types and helpers for the multi-channel filtered synchroniser.
package c3lib_sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILT_CYCLES_MAX = 255;

    typedef logic [7:0] glitch_cnt_t;

    function automatic int filt_cnt_w(input int filt_cycles);
        return $clog2(filt_cycles + 1);
    endfunction

endpackage

// File: rtl/c3lib_sync_filt_chan.sv
// One channel: sync chain, stability filter and registered edge pulses.
// With C3LIB_SYNC_FILT_GLITCH_CNT_EN a per-cycle glitch-reject flag is exported.
module c3lib_sync_filt_chan
    import c3lib_sync_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 3,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst_in,
    input  logic data_in,
`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
    output logic glitch,
`endif
    output logic data_out,
    output logic rise_pls,
    output logic fall_pls
);

    localparam int CW = filt_cnt_w(FILT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] chain;
    logic [CW-1:0]          cnt;
    logic                   sync;
    logic                   diff;
    logic                   done;

    assign sync = chain[SYNC_STAGES-1];
    assign diff = sync ^ data_out;
    assign done = diff && (cnt == LAST);

`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
    // sync fell back to data_out part-way through qualification
    assign glitch = !diff && (cnt != '0);
`endif

    always_ff @(posedge clk) begin
        if (rst_in) begin
            chain    <= {SYNC_STAGES{RESET_VAL}};
            cnt      <= '0;
            data_out <= RESET_VAL;
            rise_pls <= 1'b0;
            fall_pls <= 1'b0;
        end else begin
            chain    <= {chain[SYNC_STAGES-2:0], data_in};
            rise_pls <= done & sync;
            fall_pls <= done & ~sync;
            if (!diff) begin
                cnt <= '0;
            end else if (done) begin
                data_out <= sync;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/c3lib_sync_filt_multi.sv
// Multi-channel filtered synchroniser with edge pulses.
// Define C3LIB_SYNC_FILT_GLITCH_CNT_EN to add the saturating glitch counter.
module c3lib_sync_filt_multi
    import c3lib_sync_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b1}},
    parameter int               FILT_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data_in,
`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
    input  logic             glitch_clr,
    output glitch_cnt_t      glitch_cnt,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pls,
    output logic [WIDTH-1:0] fall_pls
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("c3lib_sync_filt_multi: WIDTH %0d out of range 1..32", WIDTH);
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("c3lib_sync_filt_multi: SYNC_STAGES %0d out of range", SYNC_STAGES);
    end
    if (FILT_CYCLES < 1 || FILT_CYCLES > FILT_CYCLES_MAX) begin : g_bad_filt
        $error("c3lib_sync_filt_multi: FILT_CYCLES %0d out of range", FILT_CYCLES);
    end

`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
    logic [WIDTH-1:0] glitch;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        c3lib_sync_filt_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RESET_VAL   (RESET_VAL[i])
        ) u_chan (
            .clk      (clk),
            .rst_in   (rst_in),
            .data_in  (data_in[i]),
`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
            .glitch   (glitch[i]),
`endif
            .data_out (data_out[i]),
            .rise_pls (rise_pls[i]),
            .fall_pls (fall_pls[i])
        );
    end

`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
    logic [8:0] sum;
    logic [8:0] nxt;

    always_comb begin
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum = sum + 9'(glitch[i]);
        end
        nxt = 9'(glitch_cnt) + sum;
    end

    always_ff @(posedge clk) begin
        if (rst_in || glitch_clr) begin
            glitch_cnt <= '0;
        end else if (nxt > 9'd255) begin
            glitch_cnt <= 8'd255;
        end else begin
            glitch_cnt <= nxt[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_c3lib_sync_filt_multi.sv
// Directed bench for c3lib_sync_filt_multi (WIDTH=4, 2 stages, 3-cycle filter).
module tb_c3lib_sync_filt_multi;

    logic       clk     = 1'b0;
    logic       rst_in  = 1'b1;
    logic [3:0] data_in = 4'b1010;
    logic [3:0] data_out;
    logic [3:0] rise_pls;
    logic [3:0] fall_pls;
`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
    logic       glitch_clr = 1'b0;
    logic [7:0] glitch_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    c3lib_sync_filt_multi #(
        .WIDTH       (4),
        .SYNC_STAGES (2),
        .RESET_VAL   (4'b1010),
        .FILT_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .data_in    (data_in),
`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
        .glitch_clr (glitch_clr),
        .glitch_cnt (glitch_cnt),
`endif
        .data_out   (data_out),
        .rise_pls   (rise_pls),
        .fall_pls   (fall_pls)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] d,
                           input logic [3:0] r, input logic [3:0] f);
        chk4({tag, "_out"}, data_out, d);
        chk4({tag, "_rise"}, rise_pls, r);
        chk4({tag, "_fall"}, fall_pls, f);
    endtask

    logic [3:0] a_do [9] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1111,
                             4'b1111, 4'b1111, 4'b1011, 4'b1011};
    logic [3:0] a_ri [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                             4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] a_fa [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0000, 4'b0000, 4'b0100, 4'b0000};

    initial begin
        // reset held, then released with data_in equal to the reset value
        repeat (3) tick();
        chk_all("rst_hold", 4'b1010, 4'b0000, 4'b0000);
`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
        chk8("rst_gcnt", glitch_cnt, 8'd0);
`endif
        rst_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all("rst_rel", 4'b1010, 4'b0000, 4'b0000);
        end

        // clean rising edge on channel 0
        data_in = 4'b1011;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_all("edge_wait", 4'b1010, 4'b0000, 4'b0000);
        end
        tick();
        chk_all("edge_hit", 4'b1011, 4'b0001, 4'b0000);
        tick();
        chk_all("edge_after", 4'b1011, 4'b0000, 4'b0000);

        // two-cycle glitch low on channel 1 is rejected
        data_in = 4'b1001;
        tick();
        tick();
        data_in = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all("glitch", 4'b1011, 4'b0000, 4'b0000);
        end
`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
        chk8("glitch_gcnt", glitch_cnt, 8'd1);
`endif

        // channel 2 high for exactly three samples: rises, then falls back
        for (int i = 0; i < 9; i++) begin
            data_in = (i < 3) ? 4'b1111 : 4'b1011;
            tick();
            chk_all("bound_a", a_do[i], a_ri[i], a_fa[i]);
        end

        // channel 2 high 2, low 1, then high: one rise, qualification restarted
        for (int i = 0; i < 10; i++) begin
            data_in = (i == 2) ? 4'b1011 : 4'b1111;
            tick();
            if (i == 7)
                chk_all("bound_b_hit", 4'b1111, 4'b0100, 4'b0000);
            else if (i < 7)
                chk_all("bound_b_wait", 4'b1011, 4'b0000, 4'b0000);
            else
                chk_all("bound_b_hold", 4'b1111, 4'b0000, 4'b0000);
        end
`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
        chk8("bound_gcnt", glitch_cnt, 8'd2);
`endif

        // channel 3 mid-qualification (cnt=2) when reset arrives
        data_in = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("mid_qual", 4'b1111, 4'b0000, 4'b0000);
        end
        rst_in = 1'b1;
        tick();
        chk_all("mid_rst", 4'b1010, 4'b0000, 4'b0000);
`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
        chk8("mid_rst_gcnt", glitch_cnt, 8'd0);
`endif
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("post_rst_wait", 4'b1010, 4'b0000, 4'b0000);
        end
        tick();
        chk_all("post_rst_hit", 4'b0111, 4'b0101, 4'b1000);

        // all four channels toggle together
        data_in = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("all_wait", 4'b0111, 4'b0000, 4'b0000);
        end
        tick();
        chk_all("all_hit", 4'b1000, 4'b1000, 4'b0111);
        tick();
        chk_all("all_after", 4'b1000, 4'b0000, 4'b0000);

`ifdef C3LIB_SYNC_FILT_GLITCH_CNT_EN
        // 300 single-sample glitches on channel 0 saturate the counter
        chk8("sat_start", glitch_cnt, 8'd0);
        for (int k = 0; k < 300; k++) begin
            data_in = 4'b1001;
            tick();
            data_in = 4'b1000;
            tick();
            if (k == 9)
                chk8("sat_partial", glitch_cnt, 8'd9);
        end
        repeat (4) tick();
        chk8("sat_full", glitch_cnt, 8'd255);
        chk_all("sat_out", 4'b1000, 4'b0000, 4'b0000);
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        chk8("sat_clr", glitch_cnt, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
